// File: rtl/branch_predict_resolve.sv
// Branch unit: direct-mapped BTB with 2-bit counters predicts in F; the branch is resolved in D.
// Optional statistics counters are enabled with `define BTB_STATS_EN.
module branch_predict_resolve #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int BTB_DEPTH = 64,
   parameter int IDX_LSB   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_f,
   input  logic              stall_d,
   input  logic              flush_d,
   input  logic [ADDR_W-1:0] pc_f,
   output logic              pred_taken_f,
   output logic [ADDR_W-1:0] pred_target_f,
   input  logic [ADDR_W-1:0] pc_d,
   input  logic [5:0]        op_d,
   input  logic [5:0]        funct_d,
   input  logic [4:0]        rt_d,
   input  logic [DATA_W-1:0] rs_val_d,
   input  logic [DATA_W-1:0] rt_val_d,
   input  logic [ADDR_W-1:0] br_target_d,
   output logic [2:0]        pcsrc_d,
   output logic [1:0]        branch_d,
   output logic              mispredict_d,
   output logic [31:0]       stat_branches,
   output logic [31:0]       stat_mispredicts
);

   localparam int IDX_W   = $clog2(BTB_DEPTH);
   localparam int TAG_LSB = IDX_LSB + IDX_W;
   localparam int TAG_W   = ADDR_W - TAG_LSB;

   localparam logic [2:0] PCSRC_KEEP    = 3'd0;
   localparam logic [2:0] PCSRC_BRANCH  = 3'd1;
   localparam logic [2:0] PCSRC_JR      = 3'd2;
   localparam logic [2:0] PCSRC_J       = 3'd3;
   localparam logic [2:0] PCSRC_RECOVER = 3'd4;

   logic              btb_valid  [BTB_DEPTH];
   logic [TAG_W-1:0]  btb_tag    [BTB_DEPTH];
   logic [ADDR_W-1:0] btb_target [BTB_DEPTH];
   logic [1:0]        btb_ctr    [BTB_DEPTH];

   logic [IDX_W-1:0]  idx_f, idx_d;
   logic [TAG_W-1:0]  tag_f, tag_d;
   logic              hit_f, hit_d;

   logic              pred_taken_q;
   logic [ADDR_W-1:0] pred_target_q;

   logic              cond_br, cond_taken, is_jr, is_j;
   logic              rs_neg, rs_zero;
   logic              pred_match;
   logic              upd_en;

   // Low PC bits below the index are word offset only.
   logic              unused_lsbs;
   assign unused_lsbs = ^{pc_f[IDX_LSB-1:0], pc_d[IDX_LSB-1:0], stall_f};

   assign idx_f = pc_f[TAG_LSB-1:IDX_LSB];
   assign tag_f = pc_f[ADDR_W-1:TAG_LSB];
   assign idx_d = pc_d[TAG_LSB-1:IDX_LSB];
   assign tag_d = pc_d[ADDR_W-1:TAG_LSB];

   assign hit_f = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
   assign hit_d = btb_valid[idx_d] && (btb_tag[idx_d] == tag_d);

   assign pred_taken_f  = hit_f && btb_ctr[idx_f][1];
   assign pred_target_f = pred_taken_f ? btb_target[idx_f] : '0;

   // Signed compares against zero reduce to sign bit and zero detect.
   assign rs_neg  = rs_val_d[DATA_W-1];
   assign rs_zero = (rs_val_d == '0);

   always_comb begin
      cond_br    = 1'b0;
      cond_taken = 1'b0;
      is_jr      = 1'b0;
      is_j       = 1'b0;
      case (op_d)
         6'h04: begin
            cond_br    = 1'b1;
            cond_taken = (rs_val_d == rt_val_d);
         end
         6'h05: begin
            cond_br    = 1'b1;
            cond_taken = (rs_val_d != rt_val_d);
         end
         6'h06: begin
            cond_br    = 1'b1;
            cond_taken = rs_neg || rs_zero;
         end
         6'h07: begin
            cond_br    = 1'b1;
            cond_taken = !rs_neg && !rs_zero;
         end
         6'h01: begin
            if (rt_d == 5'd1) begin
               cond_br    = 1'b1;
               cond_taken = !rs_neg;
            end else if (rt_d == 5'd0) begin
               cond_br    = 1'b1;
               cond_taken = rs_neg;
            end
         end
         6'h00: is_jr = (funct_d == 6'h08);
         6'h02: is_j  = 1'b1;
         default: ;
      endcase
   end

   assign pred_match = pred_taken_q && (pred_target_q == br_target_d);

   always_comb begin
      pcsrc_d      = PCSRC_KEEP;
      mispredict_d = 1'b0;
      if (rst_n && !stall_d) begin
         if (cond_br) begin
            if (cond_taken) begin
               if (!pred_match) begin
                  pcsrc_d      = PCSRC_BRANCH;
                  mispredict_d = 1'b1;
               end
            end else if (pred_taken_q) begin
               pcsrc_d      = PCSRC_RECOVER;
               mispredict_d = 1'b1;
            end
         end else if (is_jr) begin
            pcsrc_d      = PCSRC_JR;
            mispredict_d = 1'b1;
         end else if (is_j) begin
            pcsrc_d      = PCSRC_J;
            mispredict_d = 1'b1;
         end else if (pred_taken_q) begin
            pcsrc_d      = PCSRC_RECOVER;
            mispredict_d = 1'b1;
         end
      end
   end

   always_comb begin
      branch_d = 2'd0;
      if (rst_n) begin
         if (cond_br)    branch_d = 2'd1;
         else if (is_jr) branch_d = 2'd2;
         else if (is_j)  branch_d = 2'd3;
      end
   end

   // The instruction following a redirect is on the wrong path, so its prediction is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
      end else if (flush_d || mispredict_d) begin
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
      end else if (!stall_d) begin
         pred_taken_q  <= pred_taken_f;
         pred_target_q <= pred_target_f;
      end
   end

   assign upd_en = cond_br && !stall_d && !flush_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_DEPTH; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
            btb_ctr[i]    <= 2'b01;
         end
      end else if (upd_en) begin
         if (hit_d) begin
            if (cond_taken) begin
               if (btb_ctr[idx_d] != 2'b11) btb_ctr[idx_d] <= btb_ctr[idx_d] + 2'd1;
               btb_target[idx_d] <= br_target_d;
            end else if (btb_ctr[idx_d] != 2'b00) begin
               btb_ctr[idx_d] <= btb_ctr[idx_d] - 2'd1;
            end
         end else if (cond_taken) begin
            btb_valid[idx_d]  <= 1'b1;
            btb_tag[idx_d]    <= tag_d;
            btb_target[idx_d] <= br_target_d;
            btb_ctr[idx_d]    <= 2'b10;
         end
      end
   end

`ifdef BTB_STATS_EN
   logic [31:0] branches_q;
   logic [31:0] mispredicts_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branches_q    <= '0;
         mispredicts_q <= '0;
      end else if (upd_en) begin
         branches_q <= branches_q + 32'd1;
         if (mispredict_d) mispredicts_q <= mispredicts_q + 32'd1;
      end
   end

   assign stat_branches    = branches_q;
   assign stat_mispredicts = mispredicts_q;
`else
   assign stat_branches    = '0;
   assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: prediction, resolution, BTB training, aliasing, stall, flush, reset.
// Stats expectations follow BTB_STATS_EN.
module tb_branch_predict_resolve;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_f, stall_d, flush_d;
   logic [31:0] pc_f;
   logic        pred_taken_f;
   logic [31:0] pred_target_f;
   logic [31:0] pc_d;
   logic [5:0]  op_d, funct_d;
   logic [4:0]  rt_d;
   logic [31:0] rs_val_d, rt_val_d, br_target_d;
   logic [2:0]  pcsrc_d;
   logic [1:0]  branch_d;
   logic        mispredict_d;
   logic [31:0] stat_branches, stat_mispredicts;

   int compared   = 0;
   int mismatched = 0;

   branch_predict_resolve dut (
      .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
      .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
      .pc_d(pc_d), .op_d(op_d), .funct_d(funct_d), .rt_d(rt_d),
      .rs_val_d(rs_val_d), .rt_val_d(rt_val_d), .br_target_d(br_target_d),
      .pcsrc_d(pcsrc_d), .branch_d(branch_d), .mispredict_d(mispredict_d),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_d(input string tag, input logic [2:0] pcsrc, input logic mis, input logic [1:0] br);
      check({tag, ".pcsrc"}, {29'd0, pcsrc_d}, {29'd0, pcsrc});
      check({tag, ".mispredict"}, {31'd0, mispredict_d}, {31'd0, mis});
      check({tag, ".branch"}, {30'd0, branch_d}, {30'd0, br});
   endtask

   task automatic check_f(input string tag, input logic taken, input logic [31:0] tgt);
      check({tag, ".pred_taken"}, {31'd0, pred_taken_f}, {31'd0, taken});
      check({tag, ".pred_target"}, pred_target_f, tgt);
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] funct, input logic [4:0] rt,
                        input logic [31:0] rs_v, input logic [31:0] rt_v,
                        input logic [31:0] pcd, input logic [31:0] tgt, input logic [31:0] pcf);
      op_d = op; funct_d = funct; rt_d = rt;
      rs_val_d = rs_v; rt_val_d = rt_v;
      pc_d = pcd; br_target_d = tgt; pc_f = pcf;
      #1;
   endtask

   // D holds an addi: not a branch of any kind.
   task automatic idle(input logic [31:0] pcf);
      drive(6'h08, 6'h00, 5'd0, 32'd0, 32'd0, 32'h0, 32'h0, pcf);
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
      @(negedge clk);
      drive(6'h04, 6'h00, 5'd0, 32'd5, 32'd5, 32'h40, 32'h80, 32'h40);
      check_d("reset", 3'd0, 1'b0, 2'd0);
      check_f("reset", 1'b0, 32'h0);
      check("reset.stat_br", stat_branches, 32'd0);
      idle(32'h200);
      tick;
      rst_n = 1'b1;
      tick;

      // First beq: not predicted, taken -> allocate.
      drive(6'h04, 6'h00, 5'd0, 32'd5, 32'd5, 32'h40, 32'h80, 32'h44);
      check_d("beq_alloc", 3'd1, 1'b1, 2'd1);
      tick;
      idle(32'h40);
      check_f("lookup_after_alloc", 1'b1, 32'h80);
      check_d("idle_after_alloc", 3'd0, 1'b0, 2'd0);
      tick;
      // Predicted taken but not taken -> recover, ctr 10->01.
      drive(6'h04, 6'h00, 5'd0, 32'd5, 32'd6, 32'h40, 32'h80, 32'h80);
      check_d("beq_recover", 3'd4, 1'b1, 2'd1);
      tick;
      idle(32'h40);
      check_f("lookup_weak_nt", 1'b0, 32'h0);
      check_d("idle_after_recover", 3'd0, 1'b0, 2'd0);
      tick;
      // Hit with ctr 01, taken -> redirect, ctr 01->10.
      drive(6'h04, 6'h00, 5'd0, 32'd9, 32'd9, 32'h40, 32'h80, 32'h200);
      check_d("beq_hit_unpred", 3'd1, 1'b1, 2'd1);
      tick;
      idle(32'h40);
      check_f("lookup_retrained", 1'b1, 32'h80);
      tick;
      // Correctly predicted -> keep F path, ctr 10->11.
      drive(6'h04, 6'h00, 5'd0, 32'd7, 32'd7, 32'h40, 32'h80, 32'h80);
      check_d("beq_correct", 3'd0, 1'b0, 2'd1);
      tick;
      idle(32'h40);
      check_f("lookup_strong", 1'b1, 32'h80);
      tick;
      // Non-branch carrying a stale taken prediction.
      idle(32'h200);
      check_d("stale_pred", 3'd4, 1'b1, 2'd0);
      tick;

      // Signed condition checks.
      drive(6'h01, 6'h00, 5'd1, 32'd0, 32'd0, 32'h100, 32'h300, 32'h200);
      check_d("bgez_zero", 3'd1, 1'b1, 2'd1);
      tick;
      drive(6'h01, 6'h00, 5'd0, 32'hffffffff, 32'd0, 32'h104, 32'h300, 32'h200);
      check_d("bltz_neg1", 3'd1, 1'b1, 2'd1);
      tick;
      drive(6'h06, 6'h00, 5'd0, 32'd1, 32'd0, 32'h108, 32'h300, 32'h200);
      check_d("blez_one", 3'd0, 1'b0, 2'd1);
      tick;
      drive(6'h07, 6'h00, 5'd0, 32'h80000000, 32'd0, 32'h10c, 32'h300, 32'h200);
      check_d("bgtz_minint", 3'd0, 1'b0, 2'd1);
      tick;
      drive(6'h01, 6'h00, 5'd2, 32'd0, 32'd0, 32'h110, 32'h300, 32'h200);
      check_d("regimm_rt2", 3'd0, 1'b0, 2'd0);
      tick;
      drive(6'h05, 6'h00, 5'd0, 32'd1, 32'd2, 32'h114, 32'h300, 32'h200);
      check_d("bne_taken", 3'd1, 1'b1, 2'd1);
      tick;

      // Stall holds resolution and the BTB.
      stall_d = 1'b1;
      drive(6'h04, 6'h00, 5'd0, 32'd3, 32'd3, 32'h180, 32'h400, 32'h180);
      check_d("stall", 3'd0, 1'b0, 2'd1);
      check_f("stall_lookup0", 1'b0, 32'h0);
      tick;
      check_f("stall_lookup1", 1'b0, 32'h0);
      stall_d = 1'b0;
      #1;
      check_d("stall_release", 3'd1, 1'b1, 2'd1);
      tick;
      idle(32'h180);
      check_f("lookup_after_stall", 1'b1, 32'h400);
      tick;

      // Aliasing: 0x140 shares an index with 0x40. F sees the old entry this cycle.
      drive(6'h04, 6'h00, 5'd0, 32'd1, 32'd1, 32'h140, 32'h500, 32'h40);
      check_f("alias_old_entry", 1'b1, 32'h80);
      check_d("alias_alloc", 3'd1, 1'b1, 2'd1);
      tick;
      idle(32'h40);
      check_f("alias_evicted", 1'b0, 32'h0);
      tick;
      idle(32'h140);
      check_f("alias_new_entry", 1'b1, 32'h500);
      tick;

      // Jumps redirect unconditionally, taking priority over the stale prediction.
      drive(6'h00, 6'h08, 5'd0, 32'h1000, 32'd0, 32'h0, 32'h0, 32'h200);
      check_d("jr", 3'd2, 1'b1, 2'd2);
      tick;
      drive(6'h02, 6'h00, 5'd0, 32'd0, 32'd0, 32'h0, 32'h0, 32'h200);
      check_d("j", 3'd3, 1'b1, 2'd3);
      tick;

      // Flush drops the prediction that would otherwise load.
      flush_d = 1'b1;
      idle(32'h140);
      tick;
      flush_d = 1'b0;
      idle(32'h200);
      check_d("after_flush", 3'd0, 1'b0, 2'd0);
      tick;

      // Asynchronous reset mid-run.
      drive(6'h04, 6'h00, 5'd0, 32'd1, 32'd1, 32'h40, 32'h80, 32'h140);
      rst_n = 1'b0;
      #1;
      check_f("midrst", 1'b0, 32'h0);
      check_d("midrst", 3'd0, 1'b0, 2'd0);
      check("midrst.stat_br", stat_branches, 32'd0);
      check("midrst.stat_mp", stat_mispredicts, 32'd0);
      idle(32'h200);
      tick;
      rst_n = 1'b1;
      tick;

      // Three branches, one mispredicted.
      drive(6'h04, 6'h00, 5'd0, 32'd4, 32'd4, 32'h40, 32'h80, 32'h200);
      check_d("post_rst_beq", 3'd1, 1'b1, 2'd1);
      tick;
      idle(32'h40);
      check_f("post_rst_lookup", 1'b1, 32'h80);
      tick;
      drive(6'h04, 6'h00, 5'd0, 32'd4, 32'd4, 32'h40, 32'h80, 32'h200);
      check_d("post_rst_correct", 3'd0, 1'b0, 2'd1);
      tick;
      drive(6'h06, 6'h00, 5'd0, 32'd1, 32'd0, 32'h60, 32'h90, 32'h200);
      check_d("post_rst_blez", 3'd0, 1'b0, 2'd1);
      tick;
      idle(32'h200);
`ifdef BTB_STATS_EN
      check("stat_branches", stat_branches, 32'd3);
      check("stat_mispredicts", stat_mispredicts, 32'd1);
`else
      check("stat_branches", stat_branches, 32'd0);
      check("stat_mispredicts", stat_mispredicts, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
Next-generation branch unit for the 5-stage pipelined CPU. A direct-mapped branch target buffer (BTB) with 2-bit saturating counters predicts conditional branches in F. The unit carries the prediction into D, resolves the branch against register operands there, and drives the PC-source select plus a mispredict/recover indication. It replaces the purely combinational decode-stage PC-source logic. Jumps (j, jr) keep their fixed redirect behaviour.

Parameters:
DATA_W, 32, operand width (signed compare)
ADDR_W, 32, PC width
BTB_DEPTH, 64, BTB entries; power of two, ≥2
IDX_LSB, 2, lowest PC bit used for index (word-aligned PCs)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
stall_f  in  1  F stage held
stall_d  in  1  D stage held
flush_d  in  1  D-stage bubble insert
pc_f  in  ADDR_W  fetch PC
pred_taken_f  out  1  F prediction: taken
pred_target_f  out  ADDR_W  F predicted target
pc_d  in  ADDR_W  PC of instruction in D
op_d  in  6  opcode in D
funct_d  in  6  funct field in D
rt_d  in  5  rt field in D (bgez/bltz select)
rs_val_d  in  DATA_W  forwarded rs value, signed
rt_val_d  in  DATA_W  forwarded rt value, signed
br_target_d  in  ADDR_W  computed branch target in D
pcsrc_d  out  3  0 keep F path, 1 branch target, 2 jr (rs), 3 j target, 4 recover pc_d+4
branch_d  out  2  0 none, 1 cond branch, 2 jr, 3 j
mispredict_d  out  1  F path wrong; flush F
stat_branches  out  32  resolved branches (optional)
stat_mispredicts  out  32  mispredicted branches (optional)

Behaviour:
- Index = pc[IDX_LSB+log2(BTB_DEPTH)-1 : IDX_LSB]; tag = remaining upper PC bits. Entry holds valid, tag, target, ctr[1:0].
- F lookup is combinational. On hit (valid && tag match) with ctr[1]=1: pred_taken_f=1 and pred_target_f=target. Otherwise both outputs are 0.
- F→D prediction register (pred_taken, pred_target):
  - Loads when !stall_d.
  - Loads 0 when flush_d=1 or mispredict_d=1.
  - Holds when stall_d=1.
- Conditional branches in D; compares are signed:
  - op 04 beq: rs==rt.
  - op 05 bne: rs!=rt.
  - op 06 blez: rs<=0.
  - op 07 bgtz: rs>0.
  - op 01 with rt_d=1 bgez: rs>=0. With rt_d=0 bltz: rs<0. Any other rt_d: not a branch.
- pcsrc_d / mispredict_d in D, combinational:
  - stall_d=1 or rst_n=0: pcsrc=0, mispredict=0.
  - Cond branch, taken, predicted taken, target==br_target_d: pcsrc=0, mispredict=0.
  - Cond branch, taken, otherwise: pcsrc=1, mispredict=1.
  - Cond branch, not taken, predicted taken: pcsrc=4, mispredict=1.
  - Cond branch, not taken, not predicted: pcsrc=0, mispredict=0.
  - jr (op 00, funct 08): pcsrc=2. j (op 02): pcsrc=3. mispredict=1 for both (F fetched the sequential path).
  - Any non-branch with a stale predicted-taken: pcsrc=4, mispredict=1.
  - Anything else: 0.
- branch_d is the decode class only; it is 0 during reset and is independent of stall.
- BTB update: written at the clk edge when a cond branch is in D and !stall_d && !flush_d. Index and tag come from pc_d.
  - Hit, taken: ctr saturating increment; target <= br_target_d.
  - Hit, not taken: ctr saturating decrement (floor 00).
  - Miss, taken: allocate valid=1, tag, target, ctr=10 (weakly taken); overwrites any victim.
  - Miss, not taken: no write.
- Simultaneous F lookup and D update to the same index: F sees the old contents (read-before-write).
- Reset, asynchronous: all valid=0, ctr=01, targets 0, prediction register 0, stats 0. Reset mid-operation discards all state; outputs go to 0 immediately.

Optional Feature:
BTB_STATS_EN: when defined, stat_branches increments on each cond-branch update event and stat_mispredicts increments when that event also has mispredict_d=1. Both wrap at 2^32. When undefined, both ports are tied to 0 and no counter flops exist.

Test Plan:
- After reset, beq at pc_d=0x40 with rs=rt=5, br_target_d=0x80 → pcsrc=1, mispredict=1. Next cycle pc_f=0x40 → pred_taken_f=1, pred_target_f=0x80.
- Same beq refetched with prediction, rs=5, rt=6 → pcsrc=4, mispredict=1; ctr 10→01. Next lookup of 0x40 → pred_taken_f=0.
- bgez rs=0 → taken. bltz rs=-1 → taken. blez rs=1 → not taken. bgtz rs=0x80000000 → not taken (signed). op 01 with rt_d=2 → branch_d=0, pcsrc=0.
- stall_d=1 with a taken branch in D → pcsrc=0, mispredict=0, BTB unchanged; releasing the stall resolves the branch once.
- Aliasing: branch at 0x40 taken, then a branch at 0x40+4·BTB_DEPTH taken → second allocates and evicts the first. jr → pcsrc=2, j → pcsrc=3, both with mispredict=1.
- With BTB_STATS_EN: 3 branches, 1 mispredicted → stat_branches=3, stat_mispredicts=1. Assert rst_n low mid-run → both stats 0 and pred_taken_f=0 immediately.
